// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard logic: FSM states, stall-count
// encoding and the register match rule used by the stall and forwarding units.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL2 = 2'd1,
      STALL1 = 2'd2
   } state_e;

   // Number of bubbles a hazard still needs; shared with the forwarding unit.
   typedef enum logic [1:0] {
      STALL_N0 = 2'd0,
      STALL_N1 = 2'd1,
      STALL_N2 = 2'd2,
      STALL_N3 = 2'd3
   } stall_n_e;

   localparam logic [4:0] ZERO_REG      = 5'd0;
   localparam int         DEFAULT_CNT_W = 16;

   function automatic logic reg_hit(input logic [4:0] rd,
                                    input logic [4:0] rs,
                                    input logic [4:0] rt,
                                    input logic       uses_rt);
      return (rd != ZERO_REG) && ((rd == rs) || (uses_rt && (rd == rt)));
   endfunction

   function automatic stall_n_e stall_need(input logic is_branch,
                                           input logic ex_hit,
                                           input logic ex_mem_read,
                                           input logic ex_reg_write,
                                           input logic mem_hit,
                                           input logic mem_mem_read);
      stall_n_e n;
      n = STALL_N0;
      if (is_branch) begin
         // Branches compare in ID, so even ALU results in EX are too late.
         if (ex_hit && ex_mem_read)
            n = STALL_N2;
         else if (ex_hit && ex_reg_write)
            n = STALL_N1;
         else if (mem_hit && mem_mem_read)
            n = STALL_N1;
      end else if (ex_hit && ex_mem_read) begin
         n = STALL_N1;
      end
      return n;
   endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX = {W{1'b1}};
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != MAX))
         count <= count + ONE;
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-in-ID hazard detection with multi-cycle stall sequencing,
// IF/ID flush on taken control transfers and saturating event counters.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       ID_RegRs,
   input  logic [4:0]       ID_RegRt,
   input  logic             ID_UsesRt,
   input  logic             ID_IsBranch,
   input  logic             ID_BranchTaken,
   input  logic             ID_Jump,
   input  logic [4:0]       EX_Rd,
   input  logic [4:0]       MEM_Rd,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic             MEM_MemRead,
   output logic             PC_Write,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Bubble,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   state_e   state;
   state_e   state_nx;
   stall_n_e need;
   logic     ex_hit;
   logic     mem_hit;
   logic     stall;
   logic     flush;

   assign ex_hit  = reg_hit(EX_Rd,  ID_RegRs, ID_RegRt, ID_UsesRt);
   assign mem_hit = reg_hit(MEM_Rd, ID_RegRs, ID_RegRt, ID_UsesRt);
   assign need    = stall_need(ID_IsBranch, ex_hit, EX_MemRead, EX_RegWrite,
                               mem_hit, MEM_MemRead);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         state <= RUN;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      flush    = 1'b0;
      case (state)
         RUN: begin
            if (need == STALL_N0) begin
               flush = (ID_IsBranch && ID_BranchTaken) || ID_Jump;
            end else begin
               stall = 1'b1;
               // Single bubbles are re-evaluated; longer ones are held by the FSM.
               if (need != STALL_N1)
                  state_nx = STALL1;
            end
         end
         STALL2, STALL1: begin
            stall    = 1'b1;
            state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   // Reset holds the pipeline quiet regardless of the hazard inputs.
   always_comb begin
      if (!Rst) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
         IFID_Flush  = 1'b1;
      end else begin
         PC_Write    = !stall;
         IFID_Write  = !stall;
         IDEX_Bubble = stall;
         IFID_Flush  = flush;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (Clk),
      .rst_n (Rst),
      .inc   (stall),
      .count (StallCount)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (Clk),
      .rst_n (Rst),
      .inc   (flush),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed plus randomized checks of hazard_stall_controller against a
// cycle-count model of the stall/flush rules.
module tb_hazard_stall_controller;

   logic        Clk;
   logic        Rst;
   logic [4:0]  rs, rt, exrd, memrd;
   logic        urt, br, tk, jp, exrw, exmr, memmr;
   logic        pc_w, ifid_w, ifid_f, idex_b;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   int hold   = 0;   // forced stall cycles still owed by an earlier hazard
   int sc     = 0;
   int fc     = 0;

   hazard_stall_controller #(.CNT_W(16)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .ID_RegRs       (rs),
      .ID_RegRt       (rt),
      .ID_UsesRt      (urt),
      .ID_IsBranch    (br),
      .ID_BranchTaken (tk),
      .ID_Jump        (jp),
      .EX_Rd          (exrd),
      .MEM_Rd         (memrd),
      .EX_RegWrite    (exrw),
      .EX_MemRead     (exmr),
      .MEM_MemRead    (memmr),
      .PC_Write       (pc_w),
      .IFID_Write     (ifid_w),
      .IFID_Flush     (ifid_f),
      .IDEX_Bubble    (idex_b),
      .StallCount     (stall_cnt),
      .FlushCount     (flush_cnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   function automatic int model_need();
      bit exh;
      bit memh;
      exh  = (exrd != 0) && ((exrd == rs) || (urt && (exrd == rt)));
      memh = (memrd != 0) && ((memrd == rs) || (urt && (memrd == rt)));
      if (br) begin
         if (exh && exmr) return 2;
         if (exh && exrw) return 1;
         if (memh && memmr) return 1;
         return 0;
      end
      return (exh && exmr) ? 1 : 0;
   endfunction

   task automatic clear_inputs();
      rs = 0; rt = 0; exrd = 0; memrd = 0;
      urt = 0; br = 0; tk = 0; jp = 0; exrw = 0; exmr = 0; memmr = 0;
   endtask

   // Entered 1 time unit after a rising edge with this cycle's inputs applied.
   task automatic cycle(input string tag);
      int n;
      bit stl;
      bit fl;
      #2;
      n   = model_need();
      stl = (hold > 0) || (n > 0);
      fl  = !stl && ((br && tk) || jp);
      chk({tag, ".pc_write"},    {31'd0, pc_w},   {31'd0, !stl});
      chk({tag, ".ifid_write"},  {31'd0, ifid_w}, {31'd0, !stl});
      chk({tag, ".idex_bubble"}, {31'd0, idex_b}, {31'd0, stl});
      chk({tag, ".ifid_flush"},  {31'd0, ifid_f}, {31'd0, fl});
      @(posedge Clk);
      if (hold > 0) hold--;
      else if (n > 0) hold = n - 1;
      if (stl) sc = sat16(sc + 1);
      if (fl)  fc = sat16(fc + 1);
      #1;
      chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, sc);
      chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, fc);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".pc_write"},    {31'd0, pc_w},   32'd0);
      chk({tag, ".ifid_write"},  {31'd0, ifid_w}, 32'd0);
      chk({tag, ".idex_bubble"}, {31'd0, idex_b}, 32'd1);
      chk({tag, ".ifid_flush"},  {31'd0, ifid_f}, 32'd1);
      chk({tag, ".stall_cnt"},   {16'd0, stall_cnt}, 32'd0);
      chk({tag, ".flush_cnt"},   {16'd0, flush_cnt}, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      Rst = 1'b0;
      #2;
      check_reset_outputs(tag);
      hold = 0; sc = 0; fc = 0;
      clear_inputs();
      #2 Rst = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      Rst = 1'b0;
      #2;
      check_reset_outputs("por");
      #20 Rst = 1'b1;
      @(posedge Clk);
      #1;

      // Load-use, non-branch: one bubble.
      exmr = 1; exrd = 8; rs = 8;
      cycle("lu_stall");
      exmr = 0;
      cycle("lu_idle");
      chk("lu_total", {16'd0, stall_cnt}, 32'd1);

      // Load followed by a dependent taken branch: two bubbles, then flush.
      do_reset("rst_a");
      exmr = 1; exrd = 8; br = 1; rt = 8; urt = 1; tk = 1;
      cycle("ldbr_c0");
      exmr = 0; memmr = 1; memrd = 8;
      cycle("ldbr_c1");
      memmr = 0; memrd = 0;
      cycle("ldbr_flush");
      clear_inputs();
      cycle("ldbr_idle");
      chk("ldbr_stalls",  {16'd0, stall_cnt}, 32'd2);
      chk("ldbr_flushes", {16'd0, flush_cnt}, 32'd1);

      // ALU result in EX feeding beq, then load in MEM feeding beq.
      do_reset("rst_b");
      exrw = 1; exrd = 9; br = 1; rs = 9;
      cycle("alubr_stall");
      exrw = 0; exrd = 0;
      cycle("alubr_go");
      memmr = 1; memrd = 9;
      cycle("membr_stall");
      memmr = 0; memrd = 0;
      cycle("membr_go");
      chk("br_stalls", {16'd0, stall_cnt}, 32'd2);

      // $zero never creates a hazard; a jump flushes without a bubble.
      clear_inputs();
      exmr = 1; exrd = 0; rs = 0;
      cycle("zero_reg");
      clear_inputs();
      jp = 1;
      cycle("jump");
      jp = 0;
      cycle("jump_after");

      // Random traffic over a small register window to provoke hits.
      for (int i = 0; i < 400; i++) begin
         rs    = 5'($urandom_range(0, 3));
         rt    = 5'($urandom_range(0, 3));
         exrd  = 5'($urandom_range(0, 3));
         memrd = 5'($urandom_range(0, 3));
         urt   = 1'($urandom);
         br    = 1'($urandom);
         tk    = 1'($urandom);
         jp    = ($urandom_range(0, 7) == 0);
         exrw  = 1'($urandom);
         exmr  = 1'($urandom);
         memmr = 1'($urandom);
         cycle("rnd");
      end

      // Reset dropped while in STALL1 abandons the stall.
      do_reset("rst_c");
      exmr = 1; exrd = 8; br = 1; rs = 8;
      cycle("pre_abort");
      #2 Rst = 1'b0;
      #1;
      check_reset_outputs("abort");
      hold = 0; sc = 0; fc = 0;
      clear_inputs();
      @(posedge Clk);
      #2 Rst = 1'b1;
      @(posedge Clk);
      #1;
      cycle("post_abort");

      // Long held stall saturates the counter.
      do_reset("rst_d");
      exmr = 1; exrd = 8; rs = 8;
      repeat (65540) @(posedge Clk);
      sc = sat16(65540);
      #1;
      chk("sat_reached", {16'd0, stall_cnt}, 32'hFFFF);
      cycle("sat_hold");
      chk("sat_flush", {16'd0, flush_cnt}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline control block for the five-stage MIPS core: detects load-use and branch-in-ID data hazards that forwarding cannot resolve and sequences the resulting stalls and flushes. It sits beside the forwarding unit in ID and drives the PC write enable, the IF/ID write enable and flush, and the ID/EX bubble. A small FSM holds multi-cycle stalls, and saturating counters record stall and flush events for performance debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- Clk  input  1  clock, rising edge
- Rst  input  1  reset, asynchronous, active-low
- ID_RegRs, ID_RegRt  input  5  source registers of the instruction in ID
- ID_UsesRt  input  1  instruction in ID reads Rt as a source
- ID_IsBranch  input  1  instruction in ID is beq/bne/jr and resolves in ID
- ID_BranchTaken  input  1  branch/jr in ID is taken; valid only when ID_IsBranch=1
- ID_Jump  input  1  j/jal in ID
- EX_Rd, MEM_Rd  input  5  destination registers in EX and MEM
- EX_RegWrite, EX_MemRead, MEM_MemRead  input  1  control bits of EX and MEM
- PC_Write  output  1  PC register load enable
- IFID_Write  output  1  IF/ID register load enable
- IFID_Flush  output  1  zero the IF/ID register on the next edge
- IDEX_Bubble  output  1  load a NOP into ID/EX on the next edge
- StallCount, FlushCount  output  CNT_W  saturating event counters

## Operation
- FSM states: RUN, STALL2, STALL1.
- Match rule: a stage "hits" when its Rd != 0 and Rd == ID_RegRs, or Rd == ID_RegRt with ID_UsesRt=1.
- Required stall count N, evaluated in RUN only:
  - ID_IsBranch=1: EX hit with EX_MemRead -> N=2; EX hit with EX_RegWrite (not load) -> N=1; MEM hit with MEM_MemRead -> N=1; else N=0.
  - ID_IsBranch=0: EX hit with EX_MemRead -> N=1; else N=0.
- RUN, N=2: assert stall this cycle, go to STALL1. N=1: assert stall, stay in RUN (re-evaluated next cycle). N=0: no stall.
- STALL2 is reserved for an N=3 extension; it is not entered and decodes as STALL1.
- STALL1: assert stall unconditionally (inputs ignored), return to RUN.
- Stall cycle: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
- Flush: in RUN with N=0 and either (ID_IsBranch & ID_BranchTaken) or ID_Jump -> IFID_Flush=1 for one cycle; PC_Write=IFID_Write=1.
- Stall and taken branch in the same cycle: stall wins and the flush is suppressed; the branch is re-evaluated when it no longer stalls.
- Idle: PC_Write=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=0.
- StallCount increments by 1 on every clock edge where a stall is asserted. FlushCount increments by 1 on every edge where IFID_Flush=1. Both saturate at all-ones with no wrap.

## Timing
- Control outputs are combinational from the registered state and the current inputs, valid in the same cycle the hazard appears. The pipeline registers act on the next rising edge.
- State and counters update on the rising edge of Clk.
- Rst low asynchronously forces:
  - state=RUN, StallCount=0, FlushCount=0;
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=1, so the pipeline is held quiet.
- Reset asserted mid-stall abandons the stall. After release the block starts in RUN with no residual stall.
- Load followed by a dependent branch:
  - cycle 0: RUN, N=2 -> stall;
  - cycle 1: STALL1 -> stall;
  - cycle 2: the load value is in WB and the forwarding unit supplies ID.
  - Total latency is 2 bubbles.
- Load-use with a non-branch instruction: 1 bubble; MEM->EX forwarding covers the remainder.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, STALL2, STALL1);
  - localparams ZERO_REG=5'd0 and CNT_W default;
  - the stall-count encoding used by this block and the forwarding unit.
- One sub-module, sat_counter: parameterised width, async active-low reset, increment enable, saturates at all-ones. It is instantiated twice.

## Test plan
- EX_MemRead=1, EX_Rd=8, ID_RegRs=8, ID_IsBranch=0 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Bubble=1. Next cycle (EX_MemRead=0) idle. StallCount=1.
- EX_MemRead=1, EX_Rd=8, ID_IsBranch=1, ID_RegRt=8, ID_UsesRt=1, ID_BranchTaken=1 -> 2 stall cycles with IFID_Flush=0, then IFID_Flush=1 for 1 cycle. StallCount=2, FlushCount=1.
- EX_RegWrite=1, EX_Rd=9, beq with ID_RegRs=9 in ID -> exactly 1 stall. MEM_MemRead=1, MEM_Rd=9 alone -> 1 stall.
- EX_MemRead=1, EX_Rd=0, ID_RegRs=0 -> no stall. ID_Jump=1 -> IFID_Flush=1 for one cycle and no bubble.
- Enter STALL1, drop Rst mid-cycle -> outputs immediately take reset values and counters read 0. After release, idle outputs with no stall.
- Hold a stall for 65540 cycles -> StallCount reaches 16'hFFFF and stays there.
